// File: rtl/gpu_pkg.sv
//------------------------------------------------------------------------------
// gpu_pkg: sprite instruction encoding and sprite attribute layout.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package gpu_pkg;

  localparam int INSTR_W   = 35;
  localparam int CODE_LSB  = 31;
  localparam int CODE_W    = 4;
  localparam int INDEX_LSB = 23;
  localparam int INDEX_W   = 8;
  localparam int DATA_LSB  = 0;
  localparam int DATA_W    = 23;

  localparam logic [CODE_W-1:0] OP_NOP    = 4'd0;
  localparam logic [CODE_W-1:0] OP_SPRITE = 4'd1;
  localparam logic [CODE_W-1:0] OP_X      = 4'd2;
  localparam logic [CODE_W-1:0] OP_Y      = 4'd3;
  localparam logic [CODE_W-1:0] OP_HEIGHT = 4'd4;
  localparam logic [CODE_W-1:0] OP_WIDTH  = 4'd5;
  localparam logic [CODE_W-1:0] OP_COMMIT = 4'd6;
  localparam logic [CODE_W-1:0] OP_CLEAR  = 4'd7;

  localparam int SPRITE_W   = 8;
  localparam int POS_W      = 10;
  localparam int SIZE_W     = 8;
  localparam int ATTR_W     = SPRITE_W + 2 * POS_W + 2 * SIZE_W;
  localparam int NUM_FIELDS = 5;

  // Bit positions inside a per-field write-enable vector.
  localparam int FLD_WIDTH  = 0;
  localparam int FLD_HEIGHT = 1;
  localparam int FLD_Y      = 2;
  localparam int FLD_X      = 3;
  localparam int FLD_SPRITE = 4;

  typedef struct packed {
    logic [SPRITE_W-1:0] sprite;
    logic [POS_W-1:0]    x;
    logic [POS_W-1:0]    y;
    logic [SIZE_W-1:0]   height;
    logic [SIZE_W-1:0]   width;
  } sprite_attr_t;

  function automatic logic [ATTR_W-1:0] field_mask(input logic [NUM_FIELDS-1:0] en);
    sprite_attr_t m;
    m.sprite = {SPRITE_W{en[FLD_SPRITE]}};
    m.x      = {POS_W{en[FLD_X]}};
    m.y      = {POS_W{en[FLD_Y]}};
    m.height = {SIZE_W{en[FLD_HEIGHT]}};
    m.width  = {SIZE_W{en[FLD_WIDTH]}};
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sprite_attr_bank.sv
//------------------------------------------------------------------------------
// sprite_attr_bank: sprite attribute table with per-field writes and bulk load.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sprite_attr_bank
  import gpu_pkg::*;
#(
  parameter int NUM_SPRITES = 16,
  localparam int IDX_W = $clog2(NUM_SPRITES)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_FIELDS-1:0]         wr_en_i,
  input  logic [IDX_W-1:0]              wr_idx_i,
  input  logic [ATTR_W-1:0]             wr_data_i,
  input  logic                          load_i,
  input  logic [NUM_SPRITES*ATTR_W-1:0] load_data_i,
  output logic [NUM_SPRITES*ATTR_W-1:0] table_o
);

  logic [ATTR_W-1:0] mask_w;
  assign mask_w = field_mask(wr_en_i);

  generate
    for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_entry
      logic [ATTR_W-1:0] entry_q;

      // Bulk load wins over a field write; the two are never driven together.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          entry_q <= '0;
        end else if (load_i) begin
          entry_q <= load_data_i[i*ATTR_W +: ATTR_W];
        end else if (wr_idx_i == IDX_W'(i)) begin
          entry_q <= (entry_q & ~mask_w) | (wr_data_i & mask_w);
        end
      end

      assign table_o[i*ATTR_W +: ATTR_W] = entry_q;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/sprite_instruction_decoder.sv
//------------------------------------------------------------------------------
// sprite_instruction_decoder: decodes sprite instructions into a shadow table
// and copies it to the active table at the frame boundary after a COMMIT.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sprite_instruction_decoder
  import gpu_pkg::*;
#(
  parameter int NUM_SPRITES = 16,
  localparam int IDX_W = $clog2(NUM_SPRITES)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [INSTR_W-1:0] Instruction,
  input  logic               FrameStart,
  input  logic [IDX_W-1:0]   ReadIndex,
  output logic [7:0]         ReadSprite,
  output logic [9:0]         ReadX,
  output logic [9:0]         ReadY,
  output logic [7:0]         ReadHeight,
  output logic [7:0]         ReadWidth,
  output logic               CommitPending,
  output logic [7:0]         ErrorCount
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  logic [CODE_W-1:0]  code_w;
  logic [INDEX_W-1:0] index_w;
  logic [DATA_W-1:0]  data_w;
  logic               in_range_w;
  logic               unused_data_w;

  assign code_w        = Instruction[CODE_LSB +: CODE_W];
  assign index_w       = Instruction[INDEX_LSB +: INDEX_W];
  assign data_w        = Instruction[DATA_LSB +: DATA_W];
  assign in_range_w    = 32'(index_w) < NUM_SPRITES;
  assign unused_data_w = ^data_w[DATA_W-1:POS_W];

  logic [NUM_FIELDS-1:0] wr_en_w;
  sprite_attr_t          wr_data_w;
  logic                  bad_w;
  logic                  commit_w;

  always_comb begin
    wr_en_w          = '0;
    bad_w            = 1'b0;
    commit_w         = 1'b0;
    wr_data_w.sprite = data_w[SPRITE_W-1:0];
    wr_data_w.x      = data_w[POS_W-1:0];
    wr_data_w.y      = data_w[POS_W-1:0];
    wr_data_w.height = data_w[SIZE_W-1:0];
    wr_data_w.width  = data_w[SIZE_W-1:0];
    case (code_w)
      OP_NOP:    ;
      OP_SPRITE: wr_en_w[FLD_SPRITE] = 1'b1;
      OP_X:      wr_en_w[FLD_X]      = 1'b1;
      OP_Y:      wr_en_w[FLD_Y]      = 1'b1;
      OP_HEIGHT: wr_en_w[FLD_HEIGHT] = 1'b1;
      OP_WIDTH:  wr_en_w[FLD_WIDTH]  = 1'b1;
      OP_COMMIT: commit_w            = 1'b1;
      OP_CLEAR: begin
        wr_en_w   = '1;
        wr_data_w = '0;
      end
      default:   bad_w = 1'b1;
    endcase
    if ((wr_en_w != '0) && !in_range_w) begin
      wr_en_w = '0;
      bad_w   = 1'b1;
    end
  end

  logic [0:0] state_q, state_d;
  logic       copy_w;
  logic [7:0] err_q, err_d;

  assign copy_w = (state_q == ST_PENDING) && FrameStart;

  // A COMMIT arriving with the copying FrameStart is absorbed by that copy.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (commit_w)   state_d = ST_PENDING;
      ST_PENDING: if (FrameStart) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  assign err_d = (bad_w && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;

  logic [NUM_SPRITES*ATTR_W-1:0] shadow_tbl_w;
  logic [NUM_SPRITES*ATTR_W-1:0] active_tbl_w;

  sprite_attr_bank #(.NUM_SPRITES(NUM_SPRITES)) u_shadow (
    .clk_i       (Clk),
    .rst_i       (Reset),
    .wr_en_i     (wr_en_w),
    .wr_idx_i    (index_w[IDX_W-1:0]),
    .wr_data_i   (wr_data_w),
    .load_i      (1'b0),
    .load_data_i ('0),
    .table_o     (shadow_tbl_w)
  );

  sprite_attr_bank #(.NUM_SPRITES(NUM_SPRITES)) u_active (
    .clk_i       (Clk),
    .rst_i       (Reset),
    .wr_en_i     ('0),
    .wr_idx_i    ('0),
    .wr_data_i   ('0),
    .load_i      (copy_w),
    .load_data_i (shadow_tbl_w),
    .table_o     (active_tbl_w)
  );

  sprite_attr_t rd_d, rd_q;

  always_comb begin
    rd_d = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (ReadIndex == IDX_W'(i)) rd_d = active_tbl_w[i*ATTR_W +: ATTR_W];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      err_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
    end
  end

  assign ReadSprite    = rd_q.sprite;
  assign ReadX         = rd_q.x;
  assign ReadY         = rd_q.y;
  assign ReadHeight    = rd_q.height;
  assign ReadWidth     = rd_q.width;
  assign CommitPending = (state_q == ST_PENDING);
  assign ErrorCount    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_sprite_instruction_decoder.sv
//------------------------------------------------------------------------------
// tb_sprite_instruction_decoder: directed and random checks against a
// table-level model of shadow/active sprite tables.
//------------------------------------------------------------------------------
`default_nettype none

module tb_sprite_instruction_decoder;

  localparam int N  = 16;
  localparam int IW = $clog2(N);

  logic          Clk = 1'b0;
  logic          Reset;
  logic [34:0]   Instruction;
  logic          FrameStart;
  logic [IW-1:0] ReadIndex;
  logic [7:0]    ReadSprite;
  logic [9:0]    ReadX;
  logic [9:0]    ReadY;
  logic [7:0]    ReadHeight;
  logic [7:0]    ReadWidth;
  logic          CommitPending;
  logic [7:0]    ErrorCount;

  sprite_instruction_decoder #(.NUM_SPRITES(N)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Instruction   (Instruction),
    .FrameStart    (FrameStart),
    .ReadIndex     (ReadIndex),
    .ReadSprite    (ReadSprite),
    .ReadX         (ReadX),
    .ReadY         (ReadY),
    .ReadHeight    (ReadHeight),
    .ReadWidth     (ReadWidth),
    .CommitPending (CommitPending),
    .ErrorCount    (ErrorCount)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  // Model: field 0 sprite, 1 x, 2 y, 3 height, 4 width.
  int sh [N][5];
  int ac [N][5];
  bit pend;
  int err;

  function automatic logic [34:0] mk(input int code, input int idx, input int data);
    return {4'(code), 8'(idx), 23'(data)};
  endfunction

  task automatic chk(input string tag, input logic [43:0] obs, input logic [43:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input logic [34:0] ins, input bit fs);
    int code, idx, data;
    code = int'(ins[34:31]);
    idx  = int'(ins[30:23]);
    data = int'(ins[22:0]);
    if (rst) begin
      for (int i = 0; i < N; i++)
        for (int f = 0; f < 5; f++) begin
          sh[i][f] = 0;
          ac[i][f] = 0;
        end
      pend = 0;
      err  = 0;
      return;
    end
    if (pend && fs) begin
      for (int i = 0; i < N; i++)
        for (int f = 0; f < 5; f++) ac[i][f] = sh[i][f];
      pend = 0;
    end else if (code == 6) begin
      pend = 1;
    end
    if ((code >= 1 && code <= 5) || code == 7) begin
      if (idx < N) begin
        case (code)
          1: sh[idx][0] = data % 256;
          2: sh[idx][1] = data % 1024;
          3: sh[idx][2] = data % 1024;
          4: sh[idx][3] = data % 256;
          5: sh[idx][4] = data % 256;
          default: for (int f = 0; f < 5; f++) sh[idx][f] = 0;
        endcase
      end else begin
        err++;
      end
    end else if (code >= 8) begin
      err++;
    end
    if (err > 255) err = 255;
  endtask

  task automatic step(input bit rst, input logic [34:0] ins, input bit fs, input int ridx);
    logic [43:0] exp_rd;
    Reset       = rst;
    Instruction = ins;
    FrameStart  = fs;
    ReadIndex   = IW'(ridx);
    if (rst || ridx >= N) exp_rd = '0;
    else exp_rd = {8'(ac[ridx][0]), 10'(ac[ridx][1]), 10'(ac[ridx][2]),
                   8'(ac[ridx][3]), 8'(ac[ridx][4])};
    model_edge(rst, ins, fs);
    @(posedge Clk);
    #1;
    chk("read", {ReadSprite, ReadX, ReadY, ReadHeight, ReadWidth}, exp_rd);
    chk("pending", 44'(CommitPending), 44'(pend));
    chk("errcnt", 44'(ErrorCount), 44'(err));
    @(negedge Clk);
  endtask

  task automatic nop(input int ridx);
    step(0, mk(0, 0, 0), 0, ridx);
  endtask

  initial begin
    Reset = 1'b1; Instruction = '0; FrameStart = 1'b0; ReadIndex = '0;
    @(negedge Clk);
    step(1, mk(0, 0, 0), 0, 0);
    step(1, mk(6, 0, 0), 1, 0);
    chk("reset_pending", 44'(CommitPending), 44'd0);

    // Shadow writes without COMMIT never reach the active table.
    step(0, mk(1, 0, 5), 0, 0);
    step(0, mk(2, 0, 0), 0, 0);
    step(0, mk(3, 0, 0), 0, 0);
    step(0, mk(4, 0, 40), 0, 0);
    step(0, mk(5, 0, 30), 0, 0);
    step(0, mk(0, 0, 0), 1, 0);
    nop(0);
    chk("nocommit_sprite", 44'(ReadSprite), 44'd0);

    // COMMIT then FrameStart three cycles later.
    step(0, mk(6, 5, 123), 0, 0);
    nop(0); nop(0); nop(0);
    chk("pending_wait", 44'(CommitPending), 44'd1);
    step(0, mk(0, 0, 0), 1, 0);
    chk("copy_cycle_old", 44'(ReadSprite), 44'd0);
    nop(0);
    chk("commit_sprite", 44'(ReadSprite), 44'd5);
    chk("commit_height", 44'(ReadHeight), 44'd40);
    chk("commit_width", 44'(ReadWidth), 44'd30);

    // COMMIT with FrameStart in IDLE only arms the commit.
    step(0, mk(1, 1, 7), 0, 1);
    step(0, mk(6, 0, 0), 1, 1);
    nop(1);
    chk("same_cycle_nocopy", 44'(ReadSprite), 44'd0);
    step(0, mk(0, 0, 0), 1, 1);
    nop(1);
    chk("same_cycle_latecopy", 44'(ReadSprite), 44'd7);

    // Rejected instructions and saturation.
    step(0, mk(2, 20, 55), 0, 0);
    step(0, mk(9, 0, 0), 0, 0);
    chk("err_two", 44'(ErrorCount), 44'd2);
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) step(0, mk($urandom_range(8, 15), $urandom_range(0, 255), $urandom), 0, i % N);
      else step(0, mk(($urandom_range(0, 5) == 0) ? 7 : $urandom_range(1, 5),
                      $urandom_range(N, 255), $urandom), 0, i % N);
    end
    chk("err_sat", 44'(ErrorCount), 44'd255);
    step(0, mk(0, 0, 0), 1, 0);
    chk("nop_no_count", 44'(ErrorCount), 44'd255);

    // Write collides with the copy: active takes old shadow value.
    step(0, mk(2, 3, 100), 0, 3);
    step(0, mk(6, 0, 0), 0, 3);
    step(0, mk(0, 0, 0), 1, 3);
    step(0, mk(6, 0, 0), 0, 3);
    step(0, mk(2, 3, 200), 1, 3);
    nop(3);
    chk("collide_active", 44'(ReadX), 44'd100);
    step(0, mk(6, 0, 0), 0, 3);
    step(0, mk(0, 0, 0), 1, 3);
    nop(3);
    chk("collide_shadow", 44'(ReadX), 44'd200);

    // Reset discards a pending commit.
    step(0, mk(6, 0, 0), 0, 3);
    step(1, mk(2, 3, 77), 1, 3);
    chk("rst_pending", 44'(CommitPending), 44'd0);
    chk("rst_readx", 44'(ReadX), 44'd0);
    chk("rst_err", 44'(ErrorCount), 44'd0);
    step(0, mk(0, 0, 0), 1, 3);
    nop(3);
    chk("rst_nocopy", 44'(ReadX), 44'd0);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      int code;
      code = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 7) : $urandom_range(0, 15);
      step($urandom_range(0, 99) == 0, mk(code, $urandom_range(0, 19), $urandom),
           $urandom_range(0, 5) == 0, $urandom_range(0, N - 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
